// File: rtl/pll_rst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pll_rst_ctrl
//  Purpose  : PLL reset sequencer. Holds the PLL in reset, waits for lock,
//             qualifies lock stability, retries on timeout or lock bounce,
//             and reports ready / error / loss-of-lock.
//  Revision : 1.0  initial release
// ============================================================================
module pll_rst_ctrl #(
    parameter int unsigned RST_CYCLES    = 8,     // 1..65535
    parameter int unsigned LOCK_TIMEOUT  = 1000,  // 1..65535
    parameter int unsigned STABLE_CYCLES = 16,    // 1..65535
    parameter int unsigned MAX_RETRY     = 3      // 0..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       ready,
    output logic       error,
    output logic       lock_lost,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABLE    = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    // Thresholds widened by one bit so "count + 1" never wraps in a compare.
    localparam logic [16:0] c_rst_len   = 17'(RST_CYCLES);
    localparam logic [16:0] c_lock_to   = 17'(LOCK_TIMEOUT);
    localparam logic [16:0] c_stable    = 17'(STABLE_CYCLES);
    localparam logic [3:0]  c_max_retry = 4'(MAX_RETRY);

    state_t      r_state;
    logic [15:0] r_cnt;        // shared per-state counter: reset / timeout / stable
    logic [3:0]  r_retry;
    logic        r_pll_rst;
    logic        r_ready;
    logic        r_error;
    logic        r_lock_lost;

    state_t      w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [3:0]  w_retry_nxt;
    logic        w_lost_nxt;
    logic [16:0] w_cnt_inc;    // count including the sample taken at this edge
    logic [15:0] w_cnt_sat;    // saturating increment of r_cnt
    logic        w_retry_done; // retry budget already used up

    assign w_cnt_inc    = {1'b0, r_cnt} + 17'd1;
    assign w_cnt_sat    = (r_cnt == 16'hFFFF) ? r_cnt : (r_cnt + 16'd1);
    assign w_retry_done = (r_retry == c_max_retry);

    // Next-state, counter and retry decisions for the sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_lost_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RESET;
                    w_cnt_nxt   = 16'd0;
                end
            end
            S_RESET: begin
                // r_cnt counts completed reset cycles; leave after the last one.
                if (w_cnt_inc >= c_rst_len) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = w_cnt_sat;
                end
            end
            S_WAIT_LOCK: begin
                if (pll_locked) begin
                    // The sample that moves us to STABLE is the first good one.
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = 16'd1;
                end else if (w_cnt_inc >= c_lock_to) begin
                    w_cnt_nxt = 16'd0;
                    if (w_retry_done) begin
                        w_state_nxt = S_FAIL;
                    end else begin
                        w_state_nxt = S_RESET;
                        w_retry_nxt = r_retry + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_sat;
                end
            end
            S_STABLE: begin
                if (pll_locked) begin
                    if (w_cnt_inc >= c_stable) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = 16'd0;
                        w_retry_nxt = 4'd0;
                    end else begin
                        w_cnt_nxt = w_cnt_sat;
                    end
                end else begin
                    w_cnt_nxt = 16'd0;
                    if (w_retry_done) begin
                        w_state_nxt = S_FAIL;
                    end else begin
                        w_state_nxt = S_RESET;
                        w_retry_nxt = r_retry + 4'd1;
                    end
                end
            end
            S_RUN: begin
                // Loss of lock after a good run always earns one fresh attempt.
                if (!pll_locked) begin
                    w_state_nxt = S_RESET;
                    w_cnt_nxt   = 16'd0;
                    w_retry_nxt = 4'd1;
                    w_lost_nxt  = 1'b1;
                end
            end
            S_FAIL: begin
                if (start) begin
                    w_state_nxt = S_RESET;
                    w_cnt_nxt   = 16'd0;
                    w_retry_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 16'd0;
                w_retry_nxt = 4'd0;
            end
        endcase
    end

    // State, counter and retry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_retry <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_retry <= w_retry_nxt;
        end
    end

    // Output registers: decoded from the next state so they track r_state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pll_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_error     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_pll_rst   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RESET) ||
                           (w_state_nxt == S_FAIL);
            r_ready     <= (w_state_nxt == S_RUN);
            r_error     <= (w_state_nxt == S_FAIL);
            r_lock_lost <= w_lost_nxt;
        end
    end

    assign pll_rst   = r_pll_rst;
    assign ready     = r_ready;
    assign error     = r_error;
    assign lock_lost = r_lock_lost;
    assign retry_cnt = r_retry;

endmodule
`default_nettype wire

// File: doc/pll_rst_ctrl.md
PLL_RST_CTRL -- requirements
Module: pll_rst_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 8: number of cycles pll_rst is held high in the RESET state; legal range 1..65535.
REQ-002 Parameter LOCK_TIMEOUT, default 1000: consecutive WAIT_LOCK cycles without pll_locked before a retry; legal range 1..65535.
REQ-003 Parameter STABLE_CYCLES, default 16: consecutive high pll_locked samples required before ready; legal range 1..65535.
REQ-004 Parameter MAX_RETRY, default 3: retries allowed before FAIL; legal range 0..15.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  level, sampled each edge: start a lock sequence from IDLE, or restart from FAIL.
REQ-008 pll_locked  input  1  PLL LOCKED output; already synchronous to clk.
REQ-009 pll_rst  output  1  drives the PLL RST input.
REQ-010 ready  output  1  PLL locked and stable; clock outputs usable.
REQ-011 error  output  1  retry budget exhausted.
REQ-012 lock_lost  output  1  one-cycle pulse on loss of lock while in RUN.
REQ-013 retry_cnt  output  4  retries consumed in the current sequence.

Function
REQ-014 All outputs are registered; ready, pll_rst and error are Moore decodes of the state register.
REQ-015 States are IDLE, RESET, WAIT_LOCK, STABLE, RUN and FAIL.
REQ-016 pll_rst is 1 in IDLE, RESET and FAIL, and 0 otherwise.
REQ-017 ready is 1 only in RUN; error is 1 only in FAIL.
REQ-018 IDLE transition: start=1 -> RESET with cycle counter cleared; otherwise stay in IDLE.
REQ-019 RESET holds for exactly RST_CYCLES cycles, then goes to WAIT_LOCK; start is ignored.
REQ-020 WAIT_LOCK, pll_locked=1 -> STABLE with the stable count set to 1 and the timeout counter cleared.
REQ-021 WAIT_LOCK, pll_locked=0 for the LOCK_TIMEOUT-th consecutive cycle -> retry decision (REQ-024).
REQ-022 STABLE, pll_locked=1: increment the stable count; when it reaches STABLE_CYCLES go to RUN. With STABLE_CYCLES=1, go to RUN on the edge after entering STABLE.
REQ-023 STABLE, pll_locked=0: retry decision (REQ-024).
REQ-024 Retry decision: if retry_cnt==MAX_RETRY go to FAIL; otherwise increment retry_cnt and go to RESET.
REQ-025 Entering RUN clears retry_cnt to 0.
REQ-026 RUN, pll_locked=0: lock_lost=1 for exactly the cycle after that edge, retry_cnt becomes 1 and the state goes to RESET. The REQ-024 check is skipped, so MAX_RETRY=0 still re-resets once.
REQ-027 FAIL, start=1: clear retry_cnt and error, go to RESET; otherwise stay in FAIL.
REQ-028 start is ignored in RESET, WAIT_LOCK, STABLE and RUN.
REQ-029 Counters are 16 bits and saturate; none can wrap for any legal parameter value.
REQ-030 pll_locked=1 seen in IDLE, RESET or FAIL is ignored.

Reset
REQ-031 rst=1 at an edge sets: state IDLE, pll_rst=1, ready=0, error=0, lock_lost=0, retry_cnt=0, all counters 0.
REQ-032 rst has priority over every transition and over start, including mid-RESET, mid-STABLE and RUN; lock_lost is not pulsed on reset.

Verification (bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=5, MAX_RETRY=2)
REQ-033 Nominal lock: start=1 at edge 0, pll_locked rises before edge 6 and stays high.
- pll_rst stays 1 through edge 4 and is 0 after edge 4.
- ready rises after the 5th consecutive high sample of pll_locked.
- retry_cnt=0 throughout.
REQ-034 Timeout exhaustion: start=1, pll_locked held 0.
- Three RESET pulses of 4 cycles each.
- retry_cnt steps 0 -> 1 -> 2.
- After the 3rd 20-cycle timeout: error=1, pll_rst=1, ready=0.
REQ-035 Bouncing lock: pll_locked high for 3 cycles in STABLE, then low.
- retry_cnt=1 and state RESET.
- A subsequent 5-cycle high run gives ready=1 and retry_cnt=0.
REQ-036 Loss in RUN: drop pll_locked for one cycle.
- lock_lost high exactly 1 cycle; ready=0 from the next cycle.
- pll_rst=1 for 4 cycles, retry_cnt=1; relock reaches RUN again.
REQ-037 Recovery from FAIL: after REQ-034, pulse start for one cycle.
- error=0 and retry_cnt=0 next cycle; RESET sequence restarts.
REQ-038 Reset mid-operation: assert rst during STABLE and during RUN.
- Next cycle: IDLE, pll_rst=1, ready=0, lock_lost=0.
- Holding start=1 through rst deassertion enters RESET on the first edge after rst falls.
